program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//   Hardware loader/sequencer for the rv32i_sc core. Accepts a word stream over a
//   valid/ready handshake, writes the first data_count words into data BRAM and the
//   next instr_count words into instruction BRAM, then releases the core for a bounded run.
//   Sits between the host/UART stream source and the I/D bram32 write ports, pc and register_file enables.
// PARAMETERS
//   DATA_WIDTH   32   stream word and BRAM data width
//   ADDR_WIDTH   10   BRAM byte-address width (w_addr ports)
//   MAX_WORDS    256  max words per memory (2**ADDR_WIDTH/4)
//   CNT_WIDTH    9    width of word counts (holds MAX_WORDS)
//   RUN_WIDTH    16   width of run-cycle budget/counter
// PORTS
//   clk               in   1           clock
//   rst               in   1           synchronous, active-high reset
//   start             in   1           one-cycle pulse; latches counts, begins load
//   data_count        in   CNT_WIDTH   words to load into data BRAM (0 = skip)
//   instr_count       in   CNT_WIDTH   words to load into instruction BRAM (0 = skip)
//   run_cycles        in   RUN_WIDTH   core cycles to execute (0 = until halt)
//   halt              in   1           ends RUN phase early
//   s_valid           in   1           stream word valid
//   s_data            in   DATA_WIDTH  stream word
//   s_ready           out  1           loader accepts word this cycle
//   d_w_addr          out  ADDR_WIDTH  data BRAM byte address
//   d_w_dat           out  DATA_WIDTH  data BRAM write data
//   d_w_enb           out  1           data BRAM write enable
//   d_bram_init_done  out  1           hands data BRAM write port to core
//   i_w_addr          out  ADDR_WIDTH  instruction BRAM byte address
//   i_w_dat           out  DATA_WIDTH  instruction BRAM write data
//   i_w_enb           out  1           instruction BRAM write enable
//   pc_stall          out  1           pc stall
//   i_r_enb           out  1           instruction BRAM read enable
//   rd_enbl           out  1           register_file read enable
//   busy / done / error out 1 each     status
//   cycles_run        out  RUN_WIDTH   core cycles elapsed in RUN
// BEHAVIOUR
//   Reset: state IDLE; pc_stall=1; all other outputs 0. rst wins over every input.
//   States: IDLE -> CHECK -> LOAD_D -> LOAD_I -> RUN -> DONE -> IDLE.
//   IDLE: busy=0; start latches counts/run_cycles, clears done/error/cycles_run -> CHECK.
//   CHECK (1 cycle): either count > MAX_WORDS -> DONE, error=1, no writes.
//     Else -> LOAD_D if data_count!=0, else LOAD_I if instr_count!=0, else RUN.
//   LOAD_D/LOAD_I: s_ready=1; word accepted when s_valid&&s_ready. All BRAM write
//     outputs registered: cycle after word k accepted, w_enb=1 for exactly one cycle,
//     w_addr=k*4 (k from 0 per memory), w_dat=word. s_valid low stalls, no penalty.
//     After last word: LOAD_D -> LOAD_I (or RUN if instr_count==0); LOAD_I -> RUN.
//     s_ready drops the cycle after final acceptance; no extra word ever consumed.
//   d_bram_init_done: 0 until last data write pulse issued, then 1 until IDLE/reset.
//   RUN: pc_stall=0, i_r_enb=1, rd_enbl=1; cycles_run increments each cycle, saturates
//     at all-ones. Exit when cycles_run+1==run_cycles (nonzero) or halt=1 -> DONE;
//     pc_stall=1, i_r_enb=0, rd_enbl=0 from the DONE cycle on.
//   DONE: done=1 held, cycles_run frozen; start -> CHECK (new run); else stay.
//   busy=1 in CHECK/LOAD_D/LOAD_I/RUN. start ignored while busy.
//   Reset mid-load: partial BRAM contents untouched; next start restarts at address 0.
// TESTING
//   T1: data_count=2, instr_count=6, run_cycles=10, stream 8 words -> d writes @0x000,0x004;
//       i writes @0x000..0x014; exactly 10 cycles pc_stall=0; done=1; cycles_run=10.
//   T2: s_valid toggled 1/0 every cycle -> same addresses/data as T1, one enb pulse per word.
//   T3: data_count=0, instr_count=3 -> no d_w_enb, d_bram_init_done=1 before RUN.
//   T4: instr_count=257 -> error=1, done=1, no w_enb pulses, s_ready never 1.
//   T5: run_cycles=0, halt at RUN cycle 5 -> pc_stall=1 next cycle, cycles_run=5.
//   T6: rst during LOAD_I word 3 -> all outputs reset values next cycle; re-start writes from 0x000.

Source files
------------

// File: rtl/program_loader.sv
// Loader/sequencer for the rv32i_sc core: streams data and instruction words into the
// BRAM write ports, then releases pc/regfile for a bounded run.
module program_loader #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned MAX_WORDS  = 256,
   parameter int unsigned CNT_WIDTH  = 9,
   parameter int unsigned RUN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  data_count,
   input  logic [CNT_WIDTH-1:0]  instr_count,
   input  logic [RUN_WIDTH-1:0]  run_cycles,
   input  logic                  halt,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   output logic [ADDR_WIDTH-1:0] d_w_addr,
   output logic [DATA_WIDTH-1:0] d_w_dat,
   output logic                  d_w_enb,
   output logic                  d_bram_init_done,
   output logic [ADDR_WIDTH-1:0] i_w_addr,
   output logic [DATA_WIDTH-1:0] i_w_dat,
   output logic                  i_w_enb,
   output logic                  pc_stall,
   output logic                  i_r_enb,
   output logic                  rd_enbl,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [RUN_WIDTH-1:0]  cycles_run
);

   localparam logic [CNT_WIDTH-1:0] MaxCnt = CNT_WIDTH'(MAX_WORDS);
   localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);
   localparam logic [RUN_WIDTH-1:0] RunOne = RUN_WIDTH'(1);

   typedef enum logic [2:0] {StIdle, StCheck, StLoadD, StLoadI, StRun, StDone} state_e;

   state_e                 state;
   logic [CNT_WIDTH-1:0]   d_cnt;
   logic [CNT_WIDTH-1:0]   i_cnt;
   logic [CNT_WIDTH-1:0]   word_idx;
   logic [RUN_WIDTH-1:0]   run_limit;
   logic                   d_last_pend;
   logic                   accept;
   logic                   word_last;
   logic [ADDR_WIDTH-1:0]  word_addr;

   assign accept    = s_valid && s_ready;
   assign word_last = (word_idx + CntOne) == ((state == StLoadD) ? d_cnt : i_cnt);
   assign word_addr = {word_idx[ADDR_WIDTH-3:0], 2'b00};

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= StIdle;
         d_cnt            <= '0;
         i_cnt            <= '0;
         word_idx         <= '0;
         run_limit        <= '0;
         d_last_pend      <= 1'b0;
         s_ready          <= 1'b0;
         d_w_addr         <= '0;
         d_w_dat          <= '0;
         d_w_enb          <= 1'b0;
         d_bram_init_done <= 1'b0;
         i_w_addr         <= '0;
         i_w_dat          <= '0;
         i_w_enb          <= 1'b0;
         pc_stall         <= 1'b1;
         i_r_enb          <= 1'b0;
         rd_enbl          <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
         error            <= 1'b0;
         cycles_run       <= '0;
      end else begin
         d_w_enb <= 1'b0;
         i_w_enb <= 1'b0;
         // Data port is handed over only once the final data write has landed.
         if (d_last_pend) begin
            d_bram_init_done <= 1'b1;
            d_last_pend      <= 1'b0;
         end
         case (state)
            StIdle, StDone: begin
               if (start) begin
                  d_cnt            <= data_count;
                  i_cnt            <= instr_count;
                  run_limit        <= run_cycles;
                  done             <= 1'b0;
                  error            <= 1'b0;
                  cycles_run       <= '0;
                  d_bram_init_done <= 1'b0;
                  busy             <= 1'b1;
                  state            <= StCheck;
               end
            end
            StCheck: begin
               word_idx <= '0;
               if (d_cnt > MaxCnt || i_cnt > MaxCnt) begin
                  error <= 1'b1;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= StDone;
               end else if (d_cnt != '0) begin
                  s_ready <= 1'b1;
                  state   <= StLoadD;
               end else begin
                  d_bram_init_done <= 1'b1;
                  if (i_cnt != '0) begin
                     s_ready <= 1'b1;
                     state   <= StLoadI;
                  end else begin
                     pc_stall <= 1'b0;
                     i_r_enb  <= 1'b1;
                     rd_enbl  <= 1'b1;
                     state    <= StRun;
                  end
               end
            end
            StLoadD: begin
               if (accept) begin
                  d_w_enb  <= 1'b1;
                  d_w_addr <= word_addr;
                  d_w_dat  <= s_data;
                  word_idx <= word_idx + CntOne;
                  if (word_last) begin
                     word_idx    <= '0;
                     d_last_pend <= 1'b1;
                     if (i_cnt != '0) begin
                        state <= StLoadI;
                     end else begin
                        s_ready  <= 1'b0;
                        pc_stall <= 1'b0;
                        i_r_enb  <= 1'b1;
                        rd_enbl  <= 1'b1;
                        state    <= StRun;
                     end
                  end
               end
            end
            StLoadI: begin
               if (accept) begin
                  i_w_enb  <= 1'b1;
                  i_w_addr <= word_addr;
                  i_w_dat  <= s_data;
                  word_idx <= word_idx + CntOne;
                  if (word_last) begin
                     word_idx <= '0;
                     s_ready  <= 1'b0;
                     pc_stall <= 1'b0;
                     i_r_enb  <= 1'b1;
                     rd_enbl  <= 1'b1;
                     state    <= StRun;
                  end
               end
            end
            StRun: begin
               if (cycles_run != '1) begin
                  cycles_run <= cycles_run + RunOne;
               end
               // The cycle in which halt is seen still counts as a run cycle.
               if (halt || (run_limit != '0 && (cycles_run + RunOne) == run_limit)) begin
                  pc_stall <= 1'b1;
                  i_r_enb  <= 1'b0;
                  rd_enbl  <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= StDone;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table of directed and random load/run vectors
// checked against an array-based reference model, plus reset sequences.
module tb_program_loader;

   localparam int CW = 9;
   localparam int RW = 16;

   logic          clk;
   logic          rst;
   logic          start;
   logic [CW-1:0] data_count;
   logic [CW-1:0] instr_count;
   logic [RW-1:0] run_cycles;
   logic          halt;
   logic          s_valid;
   logic [31:0]   s_data;
   logic          s_ready;
   logic [9:0]    d_w_addr;
   logic [31:0]   d_w_dat;
   logic          d_w_enb;
   logic          d_bram_init_done;
   logic [9:0]    i_w_addr;
   logic [31:0]   i_w_dat;
   logic          i_w_enb;
   logic          pc_stall;
   logic          i_r_enb;
   logic          rd_enbl;
   logic          busy;
   logic          done;
   logic          error;
   logic [RW-1:0] cycles_run;

   int n_checks = 0;
   int n_fail   = 0;

   program_loader dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .data_count       (data_count),
      .instr_count      (instr_count),
      .run_cycles       (run_cycles),
      .halt             (halt),
      .s_valid          (s_valid),
      .s_data           (s_data),
      .s_ready          (s_ready),
      .d_w_addr         (d_w_addr),
      .d_w_dat          (d_w_dat),
      .d_w_enb          (d_w_enb),
      .d_bram_init_done (d_bram_init_done),
      .i_w_addr         (i_w_addr),
      .i_w_dat          (i_w_dat),
      .i_w_enb          (i_w_enb),
      .pc_stall         (pc_stall),
      .i_r_enb          (i_r_enb),
      .rd_enbl          (rd_enbl),
      .busy             (busy),
      .done             (done),
      .error            (error),
      .cycles_run       (cycles_run)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // pat: 0 = s_valid always high, 1 = toggles every cycle, 2 = random
   typedef struct {
      int dc;
      int ic;
      int rc;
      int halt_at;
      int pat;
      bit exp_err;
      int exp_cycles;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: number of run cycles is the budget, cut short by halt (1-based run cycle).
   function automatic int model_cycles(input int rc, input int halt_at);
      if (halt_at != 0 && (rc == 0 || halt_at < rc)) return halt_at;
      return rc;
   endfunction

   function automatic bit model_err(input int dc, input int ic);
      return (dc > 256) || (ic > 256);
   endfunction

   task automatic check_reset(input string tag);
      chk({tag, " pc_stall"}, pc_stall, 1);
      chk({tag, " s_ready"}, s_ready, 0);
      chk({tag, " d_w_enb"}, d_w_enb, 0);
      chk({tag, " i_w_enb"}, i_w_enb, 0);
      chk({tag, " d_w_addr"}, d_w_addr, 0);
      chk({tag, " i_w_addr"}, i_w_addr, 0);
      chk({tag, " d_w_dat"}, d_w_dat, 0);
      chk({tag, " i_w_dat"}, i_w_dat, 0);
      chk({tag, " init_done"}, d_bram_init_done, 0);
      chk({tag, " i_r_enb"}, i_r_enb, 0);
      chk({tag, " rd_enbl"}, rd_enbl, 0);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " done"}, done, 0);
      chk({tag, " error"}, error, 0);
      chk({tag, " cycles_run"}, cycles_run, 0);
   endtask

   task automatic run_vec(input int id, input vec_t v);
      logic [31:0] words[$];
      int  n_words = v.dc + v.ic;
      int  acc = 0;
      int  d_seen = 0;
      int  i_seen = 0;
      int  run_seen = 0;
      int  cyc = 0;
      bit  ready_seen = 0;
      bit  init_at_run = 0;
      bit  first_run = 1;
      bit  finished = 0;
      bit  want;
      string t;
      t = $sformatf("v%0d", id);
      for (int k = 0; k < n_words; k++) words.push_back($urandom);

      @(negedge clk);
      data_count  = CW'(v.dc);
      instr_count = CW'(v.ic);
      run_cycles  = RW'(v.rc);
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!finished && cyc < 6000) begin
         start = 1'b0;
         if (d_w_enb) begin
            if (d_seen < v.dc) begin
               chk({t, " d_addr"}, d_w_addr, 64'(d_seen * 4));
               chk({t, " d_dat"}, d_w_dat, words[d_seen]);
            end
            d_seen++;
         end
         if (i_w_enb) begin
            if (i_seen < v.ic) begin
               chk({t, " i_addr"}, i_w_addr, 64'(i_seen * 4));
               chk({t, " i_dat"}, i_w_dat, words[v.dc + i_seen]);
            end
            i_seen++;
         end
         if (!pc_stall) begin
            run_seen++;
            if (first_run) begin
               first_run   = 0;
               init_at_run = d_bram_init_done;
            end
         end
         if (s_ready) ready_seen = 1;
         if (done) finished = 1;
         halt = !pc_stall && v.halt_at != 0 && run_seen == v.halt_at;
         // A start pulse mid-load must be ignored.
         if (!v.exp_err && n_words >= 2 && cyc == 2) start = 1'b1;
         case (v.pat)
            0:       want = 1;
            1:       want = (cyc % 2) == 0;
            default: want = 1'($urandom_range(0, 1));
         endcase
         // Keep offering surplus words so over-consumption would show up.
         s_valid = want && !finished;
         s_data  = (acc < n_words) ? words[acc] : $urandom;
         if (s_valid && s_ready) acc++;
         cyc++;
         if (!finished) @(negedge clk);
      end
      s_valid = 1'b0;
      halt    = 1'b0;
      start   = 1'b0;

      chk({t, " completed"}, finished, 1);
      chk({t, " error"}, error, v.exp_err);
      chk({t, " cycles_run"}, cycles_run, 64'(v.exp_cycles));
      chk({t, " run_len"}, run_seen, 64'(v.exp_cycles));
      chk({t, " d_pulses"}, d_seen, v.exp_err ? 0 : v.dc);
      chk({t, " i_pulses"}, i_seen, v.exp_err ? 0 : v.ic);
      chk({t, " accepted"}, acc, v.exp_err ? 0 : n_words);
      chk({t, " busy"}, busy, 0);
      chk({t, " pc_stall"}, pc_stall, 1);
      chk({t, " i_r_enb"}, i_r_enb, 0);
      chk({t, " rd_enbl"}, rd_enbl, 0);
      chk({t, " init_done"}, d_bram_init_done, v.exp_err ? 0 : 1);
      if (v.exp_err) chk({t, " ready_seen"}, ready_seen, 0);
      if (!v.exp_err && v.dc == 0) chk({t, " init_before_run"}, init_at_run, 1);
      @(negedge clk);
      chk({t, " done_held"}, done, 1);
      chk({t, " cycles_frozen"}, cycles_run, 64'(v.exp_cycles));
   endtask

   initial begin
      vec_t v;
      int   acc;
      rst = 1'b1; start = 1'b0; halt = 1'b0; s_valid = 1'b0; s_data = '0;
      data_count = '0; instr_count = '0; run_cycles = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset("reset");

      //              dc   ic   rc  halt pat err cyc
      tbl.push_back('{2,   6,   10, 0,   0,  0,  10});
      tbl.push_back('{2,   6,   10, 0,   1,  0,  10});
      tbl.push_back('{0,   3,   4,  0,   0,  0,  4});
      tbl.push_back('{0,   257, 10, 0,   0,  1,  0});
      tbl.push_back('{3,   2,   0,  5,   2,  0,  5});
      tbl.push_back('{257, 1,   5,  0,   0,  1,  0});
      tbl.push_back('{0,   0,   3,  0,   0,  0,  3});
      tbl.push_back('{256, 4,   2,  0,   2,  0,  2});
      tbl.push_back('{1,   1,   20, 7,   0,  0,  7});
      tbl.push_back('{1,   0,   1,  0,   0,  0,  1});
      tbl.push_back('{0,   1,   0,  1,   1,  0,  1});
      for (int r = 0; r < 12; r++) begin
         v.dc      = $urandom_range(0, 20);
         v.ic      = $urandom_range(0, 20);
         v.rc      = $urandom_range(0, 30);
         v.halt_at = (v.rc == 0 || $urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : 0;
         v.pat     = $urandom_range(0, 2);
         v.exp_err = model_err(v.dc, v.ic);
         v.exp_cycles = v.exp_err ? 0 : model_cycles(v.rc, v.halt_at);
         tbl.push_back(v);
      end

      for (int n = 0; n < tbl.size(); n++) run_vec(n, tbl[n]);

      // Reset while loading the fourth instruction word.
      @(negedge clk);
      data_count = CW'(2); instr_count = CW'(6); run_cycles = RW'(10);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      acc = 0;
      for (int c = 0; c < 100 && acc < 5; c++) begin
         s_valid = 1'b1;
         s_data  = $urandom;
         if (s_ready) acc++;
         @(negedge clk);
      end
      chk("midload reached", acc, 5);
      rst = 1'b1;
      s_valid = 1'b0;
      @(negedge clk);
      check_reset("midload");
      rst = 1'b0;
      v = '{2, 6, 10, 0, 0, 0, 10};
      run_vec(100, v);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
